// File: rtl/lfsr_prng_param.sv
// Parameterised Fibonacci-style LFSR pseudo-random generator.
// Each advance applies STEPS single shifts combinationally within one clock.
// A single shift XORs the tapped state bits, shifts left and puts the result in bit 0.
// Zero seeds are replaced by SEED_DEFAULT so the state can never lock up at zero.
//
// Parameters:
//   WIDTH        - state width, 3..32
//   TAPS         - feedback mask; bit i set means state bit i feeds the XOR
//   STEPS        - shifts per advance, 1..WIDTH
//   SEED_DEFAULT - reset state and zero-seed substitute (nonzero)
// Ports:
//   clock     - rising-edge clock
//   reset     - asynchronous active-low reset
//   enable    - advance the state by STEPS shifts this cycle
//   load      - load seed this cycle (has priority over enable)
//   seed      - value loaded when load is high
//   out       - current LFSR state, taken straight from the register
//   out_valid - one-cycle pulse after any load or advance
//   wrap      - one-cycle pulse after an advance that lands on the start value
//   lockup    - one-cycle pulse after a zero seed was replaced
module lfsr_prng_param #(
  parameter int unsigned      WIDTH        = 11,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(11'h440),
  parameter int unsigned      STEPS        = 1,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             wrap,
  output logic             lockup
);

  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] adv_c;
  logic [WIDTH-1:0] load_val_c;
  logic             seed_zero_c;

  // One shift: parity of tapped bits enters at bit 0, MSB falls off.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  // Unrolled chain of STEPS shifts from the current state.
  always_comb begin
    adv_c = out;
    for (int unsigned i = 0; i < STEPS; i++) begin
      adv_c = shift_once(adv_c);
    end
  end

  // Zero seed would freeze the LFSR, so substitute the default.
  always_comb begin
    seed_zero_c = (seed == '0);
    load_val_c  = seed_zero_c ? SEED_DEFAULT : seed;
  end

  // State, start value and one-cycle status flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out       <= SEED_DEFAULT;
      start     <= SEED_DEFAULT;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      lockup    <= 1'b0;
    end else begin
      out_valid <= load | enable;
      wrap      <= !load && enable && (adv_c == start);
      lockup    <= load && seed_zero_c;
      if (load) begin
        out   <= load_val_c;
        start <= load_val_c;
      end else if (enable) begin
        out <= adv_c;
      end
    end
  end

endmodule
